// File: rtl/dm_ram_readout_seq.sv
// Frame readout sequencer: sweeps the actuator RAM and streams {data, chan, last}
// words to the DAC serializer through a 2-entry buffer with valid/ready flow control.
module dm_ram_readout_seq #(
    parameter int AW    = 5,
    parameter int DW    = 16,
    parameter int NCHAN = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          CLR_ERR,
    output logic [AW-1:0] RADDR,
    output logic          REN,
    input  logic [DW-1:0] RD,
    output logic [DW-1:0] M_DATA,
    output logic [AW-1:0] M_CHAN,
    output logic          M_LAST,
    output logic          M_VALID,
    input  logic          M_READY,
    output logic          BUSY,
    output logic          DONE,
    output logic          START_DROP
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NCHAN - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t          state;
    logic [1:0]      cnt;
    logic            rd_vld_p1;
    logic [AW-1:0]   rd_chan_p1;
    logic            rd_last_p1;
    logic [DW-1:0]   buf_data [2];
    logic [AW-1:0]   buf_chan [2];
    logic            buf_last [2];
    logic            pop;
    logic            push;
    logic [1:0]      wr_idx;
    logic [2:0]      outstanding;

    // Credit check counts the word leaving this cycle so a full buffer still
    // refills at one word per clock; it never lets more than two words be owed.
    assign pop         = (cnt != 2'd0) && M_READY;
    assign push        = rd_vld_p1;
    assign outstanding = {1'b0, cnt} + {2'b0, rd_vld_p1} - {2'b0, pop};
    assign REN         = (state == FETCH) && (outstanding < 3'd2);
    assign wr_idx      = cnt - {1'b0, pop};

    assign M_VALID = (cnt != 2'd0);
    assign M_DATA  = M_VALID ? buf_data[0] : '0;
    assign M_CHAN  = M_VALID ? buf_chan[0] : '0;
    assign M_LAST  = M_VALID && buf_last[0];
    assign BUSY    = (state != IDLE);

    // Control: FSM, read address, occupancy, status flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            RADDR      <= '0;
            cnt        <= 2'd0;
            rd_vld_p1  <= 1'b0;
            DONE       <= 1'b0;
            START_DROP <= 1'b0;
        end else begin
            DONE      <= 1'b0;
            rd_vld_p1 <= REN;
            cnt       <= cnt + {1'b0, push} - {1'b0, pop};
            if (START && state != IDLE)
                START_DROP <= 1'b1;
            else if (CLR_ERR)
                START_DROP <= 1'b0;
            case (state)
                IDLE: begin
                    RADDR <= '0;
                    if (START)
                        state <= FETCH;
                end
                FETCH: begin
                    if (REN) begin
                        if (RADDR == LAST_ADDR)
                            state <= DRAIN;
                        else
                            RADDR <= RADDR + AW'(1);
                    end
                end
                DRAIN: begin
                    if (pop && buf_last[0]) begin
                        state <= IDLE;
                        DONE  <= 1'b1;
                        RADDR <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data: read tag pipeline (p1 aligns with RD) and the 2-entry output FIFO
    always_ff @(posedge CLK) begin
        rd_chan_p1 <= RADDR;
        rd_last_p1 <= (RADDR == LAST_ADDR);
        if (pop) begin
            buf_data[0] <= buf_data[1];
            buf_chan[0] <= buf_chan[1];
            buf_last[0] <= buf_last[1];
        end
        if (push) begin
            if (wr_idx == 2'd0) begin
                buf_data[0] <= RD;
                buf_chan[0] <= rd_chan_p1;
                buf_last[0] <= rd_last_p1;
            end else begin
                buf_data[1] <= RD;
                buf_chan[1] <= rd_chan_p1;
                buf_last[1] <= rd_last_p1;
            end
        end
    end

endmodule

// File: tb/tb_dm_ram_readout_seq.sv
// Scoreboard bench for dm_ram_readout_seq: a 32-channel instance and an NCHAN=1 instance.
module tb_dm_ram_readout_seq;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam int NCHAN = 32;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] c;
        logic          l;
    } word_t;

    logic clk = 1'b0;
    logic rst, start, clr_err, m_ready;
    logic [AW-1:0] raddr, m_chan;
    logic ren, m_last, m_valid, busy, done, start_drop;
    logic [DW-1:0] rd, m_data;
    logic start1, m_ready1;
    logic [AW-1:0] raddr1, m_chan1;
    logic ren1, m_last1, m_valid1, busy1, done1, start_drop1;
    logic [DW-1:0] rd1, m_data1;

    logic [DW-1:0] mem [NCHAN];
    word_t sb [$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ren) rd <= mem[raddr];
        if (ren1) rd1 <= mem[raddr1];
    end

    dm_ram_readout_seq #(.AW(AW), .DW(DW), .NCHAN(NCHAN)) dut (
        .CLK(clk), .RST(rst), .START(start), .CLR_ERR(clr_err),
        .RADDR(raddr), .REN(ren), .RD(rd),
        .M_DATA(m_data), .M_CHAN(m_chan), .M_LAST(m_last), .M_VALID(m_valid), .M_READY(m_ready),
        .BUSY(busy), .DONE(done), .START_DROP(start_drop));

    dm_ram_readout_seq #(.AW(AW), .DW(DW), .NCHAN(1)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .CLR_ERR(clr_err),
        .RADDR(raddr1), .REN(ren1), .RD(rd1),
        .M_DATA(m_data1), .M_CHAN(m_chan1), .M_LAST(m_last1), .M_VALID(m_valid1), .M_READY(m_ready1),
        .BUSY(busy1), .DONE(done1), .START_DROP(start_drop1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        word_t w;
        for (int i = 0; i < NCHAN; i++) begin
            w.d = mem[i];
            w.c = AW'(i);
            w.l = (i == NCHAN - 1);
            sb.push_back(w);
        end
    endtask

    task automatic test_reset();
        rst = 1; start = 0; clr_err = 0; m_ready = 0; start1 = 0; m_ready1 = 0;
        repeat (3) step();
        @(negedge clk);
        n_cmp++;
        if ({raddr, ren, m_data, m_chan, m_last, m_valid, busy, done, start_drop} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, want 0",
                     {raddr, ren, m_data, m_chan, m_last, m_valid, busy, done, start_drop});
        end
        n_cmp++;
        if ({raddr1, ren1, m_data1, m_chan1, m_last1, m_valid1, busy1, done1, start_drop1} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_n1: got %h, want 0",
                     {raddr1, ren1, m_data1, m_chan1, m_last1, m_valid1, busy1, done1, start_drop1});
        end
        step();
        rst = 0;
    endtask

    task automatic test_basic();
        word_t exp;
        int ndone = 0;
        push_frame();
        m_ready = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            start = (cyc == 0);
            @(negedge clk);
            if (cyc == 1) begin
                n_cmp++;
                if ({ren, raddr} !== {1'b1, 5'd0}) begin
                    n_err++;
                    $display("FAIL basic_first_read: got ren=%b raddr=%0d, want ren=1 raddr=0", ren, raddr);
                end
            end
            if (m_valid && m_ready) begin
                exp = (sb.size() > 0) ? sb.pop_front() : '0;
                n_cmp++;
                if ({m_data, m_chan, m_last} !== exp || cyc != 3 + int'(exp.c)) begin
                    n_err++;
                    $display("FAIL basic_word: cyc %0d got %h/%0d/%b, want %h/%0d/%b at cyc %0d",
                             cyc, m_data, m_chan, m_last, exp.d, exp.c, exp.l, 3 + int'(exp.c));
                end
            end
            if (done) begin
                ndone++;
                n_cmp++;
                if (cyc != 35 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic_done: DONE at cyc %0d busy=%b, want cyc 35 busy=0", cyc, busy);
                end
            end
            step();
        end
        n_cmp++;
        if (sb.size() != 0 || ndone != 1) begin
            n_err++;
            $display("FAIL basic_complete: left %0d words, %0d DONE pulses, want 0 and 1", sb.size(), ndone);
        end
        sb.delete();
    endtask

    task automatic test_backpressure();
        word_t exp, held;
        logic stalled = 0;
        logic seen_done = 0;
        int outst = 0;
        held = '0;
        push_frame();
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            start = (cyc == 0);
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (stalled) begin
                n_cmp++;
                if (!m_valid || {m_data, m_chan, m_last} !== held) begin
                    n_err++;
                    $display("FAIL bp_stable: cyc %0d got v=%b %h, want v=1 %h", cyc, m_valid,
                             {m_data, m_chan, m_last}, held);
                end
            end
            if (ren) begin
                n_cmp++;
                if (outst - int'(m_valid && m_ready) >= 2) begin
                    n_err++;
                    $display("FAIL bp_ren_limit: cyc %0d REN with %0d outstanding, want < 2",
                             cyc, outst - int'(m_valid && m_ready));
                end
            end
            if (m_valid && m_ready) begin
                exp = (sb.size() > 0) ? sb.pop_front() : '0;
                n_cmp++;
                if ({m_data, m_chan, m_last} !== exp) begin
                    n_err++;
                    $display("FAIL bp_word: got %h/%0d/%b, want %h/%0d/%b",
                             m_data, m_chan, m_last, exp.d, exp.c, exp.l);
                end
            end
            if (done) seen_done = 1;
            stalled = m_valid && !m_ready;
            held = {m_data, m_chan, m_last};
            outst = outst + int'(ren) - int'(m_valid && m_ready);
            step();
        end
        n_cmp++;
        if (!seen_done || sb.size() != 0) begin
            n_err++;
            $display("FAIL bp_complete: done=%b left %0d words, want done=1 and 0", seen_done, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_full_stall();
        word_t exp;
        logic [AW-1:0] addrs [$];
        logic seen_done = 0;
        push_frame();
        m_ready = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            start = (cyc == 0);
            @(negedge clk);
            if (ren) addrs.push_back(raddr);
            if (cyc == 19) begin
                n_cmp++;
                if (!m_valid || m_chan !== 5'd0 || m_data !== mem[0]) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b chan=%0d data=%h, want v=1 chan=0 data=%h",
                             m_valid, m_chan, m_data, mem[0]);
                end
            end
            step();
        end
        n_cmp++;
        if (addrs.size() != 2 || addrs[0] !== 5'd0 || addrs[1] !== 5'd1) begin
            n_err++;
            $display("FAIL stall_ren_count: got %0d REN pulses, want 2 (addr 0,1)", addrs.size());
        end
        m_ready = 1;
        for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
            @(negedge clk);
            if (m_valid) begin
                exp = (sb.size() > 0) ? sb.pop_front() : '0;
                n_cmp++;
                if ({m_data, m_chan, m_last} !== exp) begin
                    n_err++;
                    $display("FAIL stall_word: got %h/%0d/%b, want %h/%0d/%b",
                             m_data, m_chan, m_last, exp.d, exp.c, exp.l);
                end
            end
            if (done) seen_done = 1;
            step();
        end
        n_cmp++;
        if (!seen_done || sb.size() != 0) begin
            n_err++;
            $display("FAIL stall_complete: done=%b left %0d words, want done=1 and 0", seen_done, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_start_busy();
        word_t exp;
        int ndone = 0;
        push_frame();
        m_ready = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            start = (cyc == 0 || cyc == 10 || cyc == 12);
            clr_err = (cyc == 12);
            @(negedge clk);
            if (cyc == 11 || cyc == 13) begin
                n_cmp++;
                if (start_drop !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_drop_set: cyc %0d START_DROP=%b, want 1", cyc, start_drop);
                end
            end
            if (m_valid && m_ready) begin
                exp = (sb.size() > 0) ? sb.pop_front() : '0;
                n_cmp++;
                if ({m_data, m_chan, m_last} !== exp || cyc != 3 + int'(exp.c)) begin
                    n_err++;
                    $display("FAIL busy_word: cyc %0d got %h/%0d/%b, want %h/%0d/%b",
                             cyc, m_data, m_chan, m_last, exp.d, exp.c, exp.l);
                end
            end
            if (done) ndone++;
            step();
        end
        start = 0; clr_err = 0;
        n_cmp++;
        if (ndone != 1 || sb.size() != 0 || start_drop !== 1'b1) begin
            n_err++;
            $display("FAIL busy_frame: %0d DONE, %0d left, drop=%b, want 1, 0, 1", ndone, sb.size(), start_drop);
        end
        clr_err = 1;
        step();
        clr_err = 0;
        @(negedge clk);
        n_cmp++;
        if (start_drop !== 1'b0) begin
            n_err++;
            $display("FAIL busy_clr: START_DROP=%b, want 0", start_drop);
        end
        step();
        sb.delete();
    endtask

    task automatic test_back_to_back();
        word_t exp;
        int ndone = 0;
        int npop = 0;
        push_frame();
        m_ready = 1;
        for (int cyc = 0; cyc < 75; cyc++) begin
            start = (cyc == 0);
            @(negedge clk);
            if (m_valid && m_ready) begin
                exp = (sb.size() > 0) ? sb.pop_front() : '0;
                n_cmp++;
                if ({m_data, m_chan, m_last} !== exp || cyc != (npop < NCHAN ? 3 : 38) + int'(exp.c)) begin
                    n_err++;
                    $display("FAIL b2b_word: cyc %0d got %h/%0d/%b, want %h/%0d/%b",
                             cyc, m_data, m_chan, m_last, exp.d, exp.c, exp.l);
                end
                npop++;
            end
            if (done) begin
                ndone++;
                n_cmp++;
                if (cyc != (ndone == 1 ? 35 : 70)) begin
                    n_err++;
                    $display("FAIL b2b_done: DONE %0d at cyc %0d, want %0d", ndone, cyc, ndone == 1 ? 35 : 70);
                end
                if (ndone == 1) begin
                    start = 1;
                    push_frame();
                end
            end
            step();
        end
        n_cmp++;
        if (ndone != 2 || npop != 2 * NCHAN || start_drop !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_frames: %0d DONE, %0d words, drop=%b, want 2, 64, 0", ndone, npop, start_drop);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        word_t exp;
        int ndone = 0;
        int base = 3;
        push_frame();
        m_ready = 1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            rst = (cyc == 15);
            start = (cyc == 0 || cyc == 20);
            if (cyc == 20) push_frame();
            @(negedge clk);
            if (cyc == 16) begin
                sb.delete();
                base = 23;
                n_cmp++;
                if ({raddr, ren, m_data, m_chan, m_last, m_valid, busy, done, start_drop} !== '0) begin
                    n_err++;
                    $display("FAIL midrst_outputs: got %h, want 0",
                             {raddr, ren, m_data, m_chan, m_last, m_valid, busy, done, start_drop});
                end
            end
            if (m_valid && m_ready) begin
                exp = (sb.size() > 0) ? sb.pop_front() : '0;
                n_cmp++;
                if ({m_data, m_chan, m_last} !== exp || cyc != base + int'(exp.c)) begin
                    n_err++;
                    $display("FAIL midrst_word: cyc %0d got %h/%0d/%b, want %h/%0d/%b at cyc %0d",
                             cyc, m_data, m_chan, m_last, exp.d, exp.c, exp.l, base + int'(exp.c));
                end
            end
            if (done) begin
                ndone++;
                n_cmp++;
                if (cyc != 55) begin
                    n_err++;
                    $display("FAIL midrst_done: DONE at cyc %0d, want 55", cyc);
                end
            end
            step();
        end
        rst = 0; start = 0;
        n_cmp++;
        if (ndone != 1 || sb.size() != 0) begin
            n_err++;
            $display("FAIL midrst_frame: %0d DONE, %0d left, want 1 and 0", ndone, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_nchan1();
        int nword = 0;
        int ndone = 0;
        m_ready1 = 1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            start1 = (cyc == 0);
            @(negedge clk);
            if (m_valid1) begin
                nword++;
                n_cmp++;
                if (cyc != 3 || m_chan1 !== 5'd0 || m_last1 !== 1'b1 || m_data1 !== mem[0]) begin
                    n_err++;
                    $display("FAIL n1_word: cyc %0d got %h/%0d/%b, want %h/0/1 at cyc 3",
                             cyc, m_data1, m_chan1, m_last1, mem[0]);
                end
            end
            if (done1) begin
                ndone++;
                n_cmp++;
                if (cyc != 4) begin
                    n_err++;
                    $display("FAIL n1_done: DONE at cyc %0d, want 4", cyc);
                end
            end
            step();
        end
        n_cmp++;
        if (nword != 1 || ndone != 1) begin
            n_err++;
            $display("FAIL n1_frame: %0d words, %0d DONE, want 1 and 1", nword, ndone);
        end
    endtask

    initial begin
        for (int i = 0; i < NCHAN; i++) mem[i] = 16'h1000 + 16'(i);
        test_reset();
        test_basic();
        test_backpressure();
        test_full_stall();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_nchan1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
